// File: rtl/util_switch_debounce.sv
// Multi-channel switch debouncer: per-bit synchronizer chain, stable-mismatch counter, change pulses.
// Optional sticky change interrupt is built only when UTIL_SWITCH_DEBOUNCE_IRQ_EN is defined.
module util_switch_debounce #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             irq,
    input  logic             irq_clr
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] sw_out_q;
    logic [WIDTH-1:0] sw_out_d;
    logic [WIDTH-1:0] sw_changed_q;
    logic [WIDTH-1:0] sw_changed_d;

    always_comb begin
        sync_d[0] = sw_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Terminal count is checked before incrementing, so the counter never passes TERM.
    always_comb begin
        sw_out_d     = sw_out_q;
        sw_changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (synced[i] != sw_out_q[i]) begin
                        state_d[i] = COUNT;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                COUNT: begin
                    if (synced[i] == sw_out_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == TERM) begin
                        state_d[i]      = IDLE;
                        cnt_d[i]        = '0;
                        sw_out_d[i]     = synced[i];
                        sw_changed_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            sw_out_q     <= '0;
            sw_changed_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sw_out_q     <= sw_out_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign sw_out     = sw_out_q;
    assign sw_changed = sw_changed_q;

`ifdef UTIL_SWITCH_DEBOUNCE_IRQ_EN
    logic irq_q;
    logic irq_d;

    // A new change pulse outranks a clear arriving in the same cycle.
    always_comb begin
        irq_d = irq_q;
        if (|sw_changed_q) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: doc/util_switch_debounce.md
UTIL_SWITCH_DEBOUNCE -- requirements
Module: util_switch_debounce

Interface
REQ-001 Parameter WIDTH, default 16, number of independent switch channels.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, cycles of stable mismatch before accepting a new level; legal range 2..2^24.
REQ-004 clk  input  1  system clock, rising edge only, single clock domain.
REQ-005 resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 sw_in  input  WIDTH  raw asynchronous switch levels from pins.
REQ-007 sw_out  output  WIDTH  debounced levels; drives gpio_io_i of system_ps_wrapper.
REQ-008 sw_changed  output  WIDTH  one-cycle pulse per bit when that bit of sw_out updates.
REQ-009 irq  output  1  sticky change interrupt; present only with macro, see Configuration.
REQ-010 irq_clr  input  1  synchronous clear of irq.

Function
REQ-011 Each sw_in bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synced level.
REQ-012 Each channel SHALL hold a counter of ceil(log2(DEBOUNCE_CYCLES)) bits and two states: IDLE (synced == sw_out) and COUNT (synced != sw_out).
REQ-013 IDLE: counter held at 0; mismatch -> COUNT with counter incremented to 1 in the same edge.
REQ-014 COUNT: on mismatch, counter increments; when counter == DEBOUNCE_CYCLES-1 and mismatch persists, sw_out bit takes synced level, counter -> 0, sw_changed bit = 1 for exactly one cycle, state -> IDLE.
REQ-015 COUNT: synced returns to sw_out level before terminal count -> counter -> 0, state -> IDLE, no output change, no pulse.
REQ-016 Latency: a clean input step SHALL appear on sw_out exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge sampling the new level.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES synced cycles SHALL never change sw_out.
REQ-018 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-019 Channels SHALL be fully independent; simultaneous updates on several bits produce simultaneous sw_changed bits.
REQ-020 sw_changed SHALL be registered (glitch-free).

Reset
REQ-021 resetn low SHALL immediately clear synchronizer flops, counters, state (IDLE), sw_out, sw_changed and irq to 0.
REQ-022 Reset mid-COUNT SHALL discard the count; after release, counting restarts from 0.
REQ-023 A switch held high through reset SHALL produce sw_out = 1 and one sw_changed pulse SYNC_STAGES + DEBOUNCE_CYCLES edges after resetn deasserts.

Configuration
REQ-024 Macro UTIL_SWITCH_DEBOUNCE_IRQ_EN SHALL gate the interrupt logic.
REQ-025 Defined: irq set to 1 on the edge following any sw_changed bit high; held until irq_clr sampled high; set wins over simultaneous irq_clr.
REQ-026 Undefined: irq tied to 0, irq_clr ignored, no irq flops instantiated; all other behaviour identical.

Verification (WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=8)
REQ-027 Reset, sw_in=0x0000, step bit0 to 1 -> sw_out=0x0001 exactly 10 edges later, sw_changed=0x0001 for one cycle.
REQ-028 Bit3 pulses high for 5 cycles then low -> sw_out stays 0x0000, sw_changed never asserted.
REQ-029 sw_in 0x0000 -> 0xA5A5 on one edge -> sw_out=0xA5A5 and sw_changed=0xA5A5 on the same cycle, 10 edges later.
REQ-030 Bit7 high, resetn pulsed low after 4 mismatch cycles -> outputs 0 immediately; sw_out bit7 = 1 10 edges after release.
REQ-031 With UTIL_SWITCH_DEBOUNCE_IRQ_EN: change on bit15 -> irq=1 the cycle after the pulse; irq_clr asserted in the same cycle as a new sw_changed -> irq remains 1; irq_clr alone -> irq=0 next cycle.
REQ-032 Without macro: repeat REQ-031 stimulus -> irq constantly 0, sw_out/sw_changed identical to REQ-031 run.
